// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
//   Definitions shared by the mux8_scan sequencer and its settle timer.
//   - state_e : sequencer state encoding (IDLE / SCAN / DONE)
//   - NCH     : number of mux channels scanned per pass
//   - SEL_W   : width of the channel select bus driven to the mux
//   - LAST_CH : select value of the final channel in a pass
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mux8_scan_timer.sv
// -----------------------------------------------------------------------------
// mux8_scan_timer
//   Loadable down-counter that times the settle interval after each select
//   change. It counts down to zero and then holds at zero until reloaded.
//
//   Ports:
//     clk_i      : rising-edge clock
//     rst_i      : synchronous active-high reset (count returns to 0)
//     load_i     : load load_val_i into the counter (wins over dec_i)
//     dec_i      : decrement request, ignored while the count is already 0
//     load_val_i : value loaded on load_i
//     zero_o     : high while the count is 0
// -----------------------------------------------------------------------------
module mux8_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux8_scan.sv
// -----------------------------------------------------------------------------
// mux8_scan
//   Scans an external 8-to-1 data selector (mux8_1 / 74LS151) channel by
//   channel and assembles the eight Y samples into a parallel byte.
//   Each channel is held for SETTLE+1 cycles; Y is sampled in the last one.
//
//   Parameters:
//     SETTLE   : extra wait cycles after each select change (0..15)
//     SETTLE_W : width of the settle counter, must hold SETTLE
//
//   Ports:
//     clk           : rising-edge clock
//     rst           : synchronous active-high reset
//     start         : request one scan of channels 0..7 (ignored while busy)
//     Y             : mux data output, only looked at while G_n = 0
//     DS2..DS0      : channel select to the mux
//     G_n           : active-low mux strobe, low only while scanning
//     data          : last completed byte, data[k] = Y with select = k
//     valid         : one-cycle pulse when data has just been updated
//     busy          : scan in progress
//
//   Handshake: start is a level request sampled on each rising edge while
//   the sequencer is in IDLE or DONE; valid is a single-cycle strobe with no
//   back-pressure, and data stays stable until the next valid.
// -----------------------------------------------------------------------------
module mux8_scan
    import mux_scan_pkg::*;
#(
    parameter int SETTLE   = 1,
    parameter int SETTLE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    output logic       DS0,
    output logic       DS1,
    output logic       DS2,
    output logic       G_n,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    state_e                 state_q;
    state_e                 state_d;
    logic [SEL_W-1:0]       sel_q;
    logic [SEL_W-1:0]       sel_d;
    logic [NCH-1:0]         cap_q;
    logic [NCH-1:0]         cap_d;
    logic [NCH-1:0]         data_q;
    logic [NCH-1:0]         data_d;

    logic                   tmr_load;
    logic                   tmr_dec;
    logic                   tmr_zero;

    mux8_scan_timer #(
        .W (SETTLE_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (SETTLE_V),
        .zero_o     (tmr_zero)
    );

    // State and datapath registers. Reset discards any partial capture and
    // clears the published byte as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
        end
    end

    // Next-state, select, capture and timer control.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cap_d    = cap_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        case (state_q)
            SCAN: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    cap_d[sel_q] = Y;
                    if (sel_q == LAST_CH) begin
                        // Publish the byte including the sample taken now.
                        data_d  = {Y, cap_q[NCH-2:0]};
                        state_d = DONE;
                    end else begin
                        sel_d    = sel_q + SEL_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end

            // IDLE and DONE behave alike: start launches a scan, otherwise
            // the sequencer rests in IDLE. Select is left where it was so DS
            // holds 111 through DONE.
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SCAN;
                    sel_d    = '0;
                    tmr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so Y and start never reach them
    // combinationally.
    always_comb begin
        G_n   = (state_q != SCAN);
        busy  = (state_q == SCAN);
        valid = (state_q == DONE);
        DS0   = sel_q[0];
        DS1   = sel_q[1];
        DS2   = sel_q[2];
        data  = data_q;
    end

endmodule

// File: tb/tb_mux8_scan.sv
// -----------------------------------------------------------------------------
// tb_mux8_scan
//   Two sequencers: dut_a with SETTLE=1 and dut_b with SETTLE=0, each driving
//   a behavioural mux8_1 model (Y = 0 while the strobe is high, else D[sel]).
//   Stimulus pushes the expected byte and its valid cycle into queues; a
//   monitor per DUT pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_mux8_scan;

    logic clk;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // dut_a (SETTLE = 1)
    logic       rst_a, start_a, yz_a;
    logic [7:0] d_a;
    wire        y_a;
    logic       ds0_a, ds1_a, ds2_a, g_n_a, valid_a, busy_a;
    logic [7:0] data_a;

    // dut_b (SETTLE = 0)
    logic       rst_b, start_b;
    logic [7:0] d_b;
    wire        y_b;
    logic       ds0_b, ds1_b, ds2_b, g_n_b, valid_b, busy_b;
    logic [7:0] data_b;

    logic [7:0] exp_a_q[$];
    int         cyc_a_q[$];
    logic [7:0] exp_b_q[$];
    int         cyc_b_q[$];

    // mux8_1 models; dut_a's can float Y while the strobe is inactive.
    assign y_a = g_n_a ? (yz_a ? 1'bz : 1'b0) : d_a[{ds2_a, ds1_a, ds0_a}];
    assign y_b = g_n_b ? 1'b0 : d_b[{ds2_b, ds1_b, ds0_b}];

    mux8_scan #(.SETTLE(1), .SETTLE_W(4)) dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .start (start_a),
        .Y     (y_a),
        .DS0   (ds0_a),
        .DS1   (ds1_a),
        .DS2   (ds2_a),
        .G_n   (g_n_a),
        .data  (data_a),
        .valid (valid_a),
        .busy  (busy_a)
    );

    mux8_scan #(.SETTLE(0), .SETTLE_W(4)) dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .start (start_b),
        .Y     (y_b),
        .DS0   (ds0_b),
        .DS1   (ds1_b),
        .DS2   (ds2_b),
        .G_n   (g_n_b),
        .data  (data_b),
        .valid (valid_b),
        .busy  (busy_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; start is sampled on the next edge (cyc+1) and
    // valid appears 16 edges later.
    task automatic start_scan_a(input logic [7:0] d);
        d_a     = d;
        start_a = 1'b1;
        exp_a_q.push_back(d);
        cyc_a_q.push_back(cyc + 17);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected_valid", valid_a, 0);
            end else begin
                logic [7:0] e;
                int t;
                e = exp_a_q.pop_front();
                t = cyc_a_q.pop_front();
                chk("a_data", data_a, e);
                chk("a_valid_cycle", cyc, t);
                chk("a_busy_in_done", busy_a, 0);
                chk("a_gn_in_done", g_n_a, 1);
                chk("a_ds_in_done", {ds2_a, ds1_a, ds0_a}, 7);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected_valid", valid_b, 0);
            end else begin
                logic [7:0] e;
                int t;
                e = exp_b_q.pop_front();
                t = cyc_b_q.pop_front();
                chk("b_data", data_b, e);
                chk("b_valid_cycle", cyc, t);
                chk("b_busy_in_done", busy_b, 0);
                chk("b_gn_in_done", g_n_b, 1);
                chk("b_ds_in_done", {ds2_b, ds1_b, ds0_b}, 7);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst_a = 1'b1; start_a = 1'b1; yz_a = 1'b0; d_a = 8'h00;
        rst_b = 1'b1; start_b = 1'b0; d_b = 8'h00;

        // Reset with start held high: everything stays at reset values.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gn", g_n_a, 1);
            chk("rst_ds", {ds2_a, ds1_a, ds0_a}, 0);
            chk("rst_data", data_a, 8'h00);
            chk("rst_valid", valid_a, 0);
            chk("rst_busy", busy_a, 0);
        end
        rst_a   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("no_scan_after_rst_busy", busy_a, 0);
        chk("no_scan_after_rst_gn", g_n_a, 1);

        // Basic scan, A5: each select held two cycles with strobe low.
        start_scan_a(8'hA5);
        for (int j = 0; j < 16; j++) begin
            chk("basic_ds", {ds2_a, ds1_a, ds0_a}, j / 2);
            chk("basic_gn", g_n_a, 0);
            chk("basic_busy", busy_a, 1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // start pulsed in the middle of a scan is ignored.
        c = cyc;
        start_scan_a(8'h5A);
        wait_until(c + 5);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("mid_start_busy", busy_a, 1);
        repeat (30) @(negedge clk);
        chk("mid_start_idle", busy_a, 0);

        // Y floating while the strobe is high must not disturb anything.
        yz_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("z_idle_data_held", data_a, 8'h5A);
        start_scan_a(8'h00);
        repeat (20) @(negedge clk);
        chk("z_scan_data", data_a, 8'h00);
        yz_a = 1'b0;

        // Reset in the middle of a scan, after a scan that left FF.
        start_scan_a(8'hFF);
        repeat (18) @(negedge clk);
        c = cyc;
        start_scan_a(8'hA5);
        wait_until(c + 9);
        chk("rstmid_pre_ds", {ds2_a, ds1_a, ds0_a}, 4);
        chk("rstmid_pre_data", data_a, 8'hFF);
        rst_a = 1'b1;
        void'(exp_a_q.pop_back());
        void'(cyc_a_q.pop_back());
        @(negedge clk);
        rst_a = 1'b0;
        chk("rstmid_gn", g_n_a, 1);
        chk("rstmid_ds", {ds2_a, ds1_a, ds0_a}, 0);
        chk("rstmid_data", data_a, 8'h00);
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_valid", valid_a, 0);
        repeat (25) @(negedge clk);
        chk("rstmid_data_after", data_a, 8'h00);

        // Back-to-back scans on dut_b (SETTLE = 0), start held high.
        rst_b = 1'b0;
        @(negedge clk);
        c = cyc;
        d_b = 8'h3C;
        start_b = 1'b1;
        exp_b_q.push_back(8'h3C);
        cyc_b_q.push_back(c + 9);
        exp_b_q.push_back(8'hC3);
        cyc_b_q.push_back(c + 18);
        wait_until(c + 8);
        chk("b2b_gn_before_done", g_n_b, 0);
        wait_until(c + 9);
        chk("b2b_gn_done", g_n_b, 1);
        d_b = 8'hC3;
        wait_until(c + 10);
        chk("b2b_gn_rescan", g_n_b, 0);
        chk("b2b_ds_rescan", {ds2_b, ds1_b, ds0_b}, 0);
        start_b = 1'b0;
        wait_until(c + 20);
        chk("b2b_idle_busy", busy_b, 0);
        chk("b2b_idle_gn", g_n_b, 1);
        chk("b2b_data_held", data_b, 8'hC3);
        repeat (5) @(negedge clk);

        chk("a_missing_valid", exp_a_q.size(), 0);
        chk("b_missing_valid", exp_b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
